// File: rtl/fb_scanout.sv
// Framebuffer scan-out: Avalon-MM burst reads into a show-ahead pixel FIFO, one Avalon-ST packet per frame.
// Define FB_SCANOUT_TESTPAT_EN to add the test_mode input and the internal 8-bar colour generator.
module fb_scanout #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned PIXEL_W    = 24,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [ADDR_W-1:0]          fb_base,
`ifdef FB_SCANOUT_TESTPAT_EN
  input  logic                       test_mode,
`endif
  output logic [ADDR_W-1:0]          avm_address,
  output logic                       avm_read,
  output logic [$clog2(BURST_LEN):0] avm_burstcount,
  input  logic                       avm_waitrequest,
  input  logic [31:0]                avm_readdata,
  input  logic                       avm_readdatavalid,
  output logic [PIXEL_W-1:0]         aso_data,
  output logic                       aso_valid,
  input  logic                       aso_ready,
  output logic                       aso_startofpacket,
  output logic                       aso_endofpacket,
  output logic                       frame_done,
  output logic                       underflow
);

  localparam int unsigned XW   = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned YW   = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int unsigned NPIX = H_RES * V_RES;
  localparam int unsigned WLW  = $clog2(NPIX + 1);
  localparam int unsigned BCW  = $clog2(BURST_LEN) + 1;
  localparam int unsigned FAW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW  = FAW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, DRAIN} state_t;

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    ptr;
  logic [WLW-1:0]       words_left, wl_after;
  logic [BCW-1:0]       bcnt, bc_next;
  logic [FCW-1:0]       outstanding, fcount;
  logic [FAW-1:0]       wr_ptr, rd_ptr;
  logic [PIXEL_W-1:0]   mem [FIFO_DEPTH];
  logic [XW-1:0]        x;
  logic [YW-1:0]        y;
  logic [PIXEL_W-1:0]   bar_color;
  logic                 pat, pat_sel, start, accept, rdv, beat, pop, first_px, last_px;
  int                   free_now, free_after;
  logic                 unused_hi;

  function automatic logic [BCW-1:0] burst_of(input logic [WLW-1:0] wl);
    return (32'(wl) >= BURST_LEN) ? BCW'(BURST_LEN) : BCW'(wl);
  endfunction

  assign unused_hi = ^avm_readdata[31:PIXEL_W];

  assign accept     = (state == ISSUE) && !avm_waitrequest;
  assign rdv        = avm_readdatavalid && (state != IDLE);
  assign first_px   = (x == '0) && (y == '0);
  assign last_px    = (x == XW'(H_RES - 1)) && (y == YW'(V_RES - 1));
  assign aso_valid  = (state != IDLE) && (pat || (fcount != '0));
  assign beat       = aso_valid && aso_ready;
  assign pop        = beat && !pat;
  assign aso_startofpacket = aso_valid && first_px;
  assign aso_endofpacket   = aso_valid && last_px;
  assign frame_done = beat && last_px;

  assign avm_read       = (state == ISSUE);
  assign avm_address    = ptr;
  assign avm_burstcount = bcnt;

  assign wl_after   = words_left - WLW'(bcnt);
  assign bc_next    = burst_of(wl_after);
  // Free FIFO slots not yet promised to in-flight reads
  assign free_now   = int'(FIFO_DEPTH) - int'(fcount) - int'(outstanding);
  assign free_after = free_now - int'(bcnt);

`ifdef FB_SCANOUT_TESTPAT_EN
  logic [2:0] bar;
  assign pat_sel = test_mode;
  assign bar     = 3'((32'(x) * 8) / H_RES);
  always_comb begin
    bar_color = '0;
    case (bar)
      3'd0: bar_color = PIXEL_W'(24'hFFFFFF);
      3'd1: bar_color = PIXEL_W'(24'hFFFF00);
      3'd2: bar_color = PIXEL_W'(24'h00FFFF);
      3'd3: bar_color = PIXEL_W'(24'h00FF00);
      3'd4: bar_color = PIXEL_W'(24'hFF00FF);
      3'd5: bar_color = PIXEL_W'(24'hFF0000);
      3'd6: bar_color = PIXEL_W'(24'h0000FF);
      default: bar_color = PIXEL_W'(24'h000000);
    endcase
  end
`else
  assign pat_sel   = 1'b0;
  assign bar_color = '0;
`endif

  always_comb begin
    aso_data = '0;
    if (aso_valid) aso_data = pat ? bar_color : mem[rd_ptr];
  end

  // Fetch FSM; frame starts happen only in IDLE or on the EOP beat in DRAIN
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          start     = 1'b1;
          state_nxt = pat_sel ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (!avm_waitrequest) begin
          if (wl_after == '0)                  state_nxt = DRAIN;
          else if (free_after >= int'(bc_next)) state_nxt = ISSUE;
          else                                 state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (free_now >= int'(BURST_LEN)) state_nxt = ISSUE;
      end
      DRAIN: begin
        if (frame_done) begin
          if (enable) begin
            start     = 1'b1;
            state_nxt = pat_sel ? DRAIN : ISSUE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      words_left  <= '0;
      bcnt        <= '0;
      outstanding <= '0;
      fcount      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      x           <= '0;
      y           <= '0;
      pat         <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        ptr        <= fb_base;
        words_left <= pat_sel ? '0 : WLW'(NPIX);
        bcnt       <= pat_sel ? '0 : burst_of(WLW'(NPIX));
        pat        <= pat_sel;
      end else if (accept) begin
        ptr        <= ptr + (ADDR_W'(bcnt) << 2);
        words_left <= wl_after;
        bcnt       <= bc_next;
      end
      outstanding <= outstanding + (accept ? FCW'(bcnt) : FCW'(0)) - (rdv ? FCW'(1) : FCW'(0));
      fcount      <= fcount + (rdv ? FCW'(1) : FCW'(0)) - (pop ? FCW'(1) : FCW'(0));
      if (rdv) wr_ptr <= wr_ptr + FAW'(1);
      if (pop) rd_ptr <= rd_ptr + FAW'(1);
      if (beat) begin
        if (x == XW'(H_RES - 1)) begin
          x <= '0;
          y <= (y == YW'(V_RES - 1)) ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
      if ((state != IDLE) && !first_px && !aso_valid && aso_ready) underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rdv) mem[wr_ptr] <= avm_readdata[PIXEL_W-1:0];
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: an 8x2 instance (A), a 6x1 instance (B) and, with
// FB_SCANOUT_TESTPAT_EN defined, a 16x1 colour-bar instance (C).
`timescale 1ns/1ps
module tb_fb_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic reset = 1'b1;

  // Instance A signals
  logic        a_en = 1'b0, a_ready = 1'b0, a_wait = 1'b0, a_rdv = 1'b0;
  logic [31:0] a_base = '0, a_addr, a_rdata = '0;
  logic        a_read, a_valid, a_sop, a_eop, a_fd, a_uf;
  logic [2:0]  a_bc;
  logic [23:0] a_data;
  int          a_gap = 1;
  logic [31:0] a_qa[$];
  int          a_qd[$];
  logic [31:0] a_baddr[$];
  int          a_bcnt[$];
  logic [23:0] a_bdat[$];
  logic [2:0]  a_bflag[$];

  // Instance B signals
  logic        b_en = 1'b0, b_rdv = 1'b0;
  logic [31:0] b_base = '0, b_addr, b_rdata = '0;
  logic        b_read, b_valid, b_sop, b_eop, b_fd, b_uf;
  logic [2:0]  b_bc;
  logic [23:0] b_data;
  logic [31:0] b_qa[$];
  int          b_qd[$];
  logic [31:0] b_baddr[$];
  int          b_bcnt[$];
  logic [23:0] b_bdat[$];
  logic [2:0]  b_bflag[$];

  fb_scanout #(.H_RES(8), .V_RES(2), .PIXEL_W(24), .ADDR_W(32), .BURST_LEN(4), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .reset(reset), .enable(a_en), .fb_base(a_base),
`ifdef FB_SCANOUT_TESTPAT_EN
    .test_mode(1'b0),
`endif
    .avm_address(a_addr), .avm_read(a_read), .avm_burstcount(a_bc), .avm_waitrequest(a_wait),
    .avm_readdata(a_rdata), .avm_readdatavalid(a_rdv),
    .aso_data(a_data), .aso_valid(a_valid), .aso_ready(a_ready),
    .aso_startofpacket(a_sop), .aso_endofpacket(a_eop), .frame_done(a_fd), .underflow(a_uf));

  fb_scanout #(.H_RES(6), .V_RES(1), .PIXEL_W(24), .ADDR_W(32), .BURST_LEN(4), .FIFO_DEPTH(8)) dut_b (
    .clk(clk), .reset(reset), .enable(b_en), .fb_base(b_base),
`ifdef FB_SCANOUT_TESTPAT_EN
    .test_mode(1'b0),
`endif
    .avm_address(b_addr), .avm_read(b_read), .avm_burstcount(b_bc), .avm_waitrequest(1'b0),
    .avm_readdata(b_rdata), .avm_readdatavalid(b_rdv),
    .aso_data(b_data), .aso_valid(b_valid), .aso_ready(1'b1),
    .aso_startofpacket(b_sop), .aso_endofpacket(b_eop), .frame_done(b_fd), .underflow(b_uf));

  // Memory word at byte address a: junk top byte, pixel = {5C, a[15:0]}
  function automatic logic [31:0] mw(input logic [31:0] a);
    return {8'hAB, 8'h5C, a[15:0]};
  endfunction

  function automatic logic [23:0] px(input logic [31:0] base, input int i);
    logic [31:0] a;
    a = base + 32'(4 * i);
    return {8'h5C, a[15:0]};
  endfunction

  // Memory models and stream monitors, all at the falling edge
  always @(negedge clk) begin
    if (a_read && !a_wait) begin
      a_baddr.push_back(a_addr);
      a_bcnt.push_back(int'(a_bc));
      for (int k = 0; k < int'(a_bc); k++) begin
        a_qa.push_back(a_addr + 32'(4 * k));
        a_qd.push_back(cyc + 2 + k * a_gap);
      end
    end
    a_rdv   = 1'b0;
    a_rdata = '0;
    if (a_qa.size() > 0 && a_qd[0] <= cyc) begin
      a_rdv   = 1'b1;
      a_rdata = mw(a_qa.pop_front());
      void'(a_qd.pop_front());
    end
    if (a_valid && a_ready) begin
      a_bdat.push_back(a_data);
      a_bflag.push_back({a_sop, a_eop, a_fd});
    end
  end

  always @(negedge clk) begin
    if (b_read) begin
      b_baddr.push_back(b_addr);
      b_bcnt.push_back(int'(b_bc));
      for (int k = 0; k < int'(b_bc); k++) begin
        b_qa.push_back(b_addr + 32'(4 * k));
        b_qd.push_back(cyc + 2 + k);
      end
    end
    b_rdv   = 1'b0;
    b_rdata = '0;
    if (b_qa.size() > 0 && b_qd[0] <= cyc) begin
      b_rdv   = 1'b1;
      b_rdata = mw(b_qa.pop_front());
      void'(b_qd.pop_front());
    end
    if (b_valid) begin
      b_bdat.push_back(b_data);
      b_bflag.push_back({b_sop, b_eop, b_fd});
    end
  end

`ifdef FB_SCANOUT_TESTPAT_EN
  logic        c_en = 1'b0;
  logic [31:0] c_addr;
  logic        c_read, c_valid, c_sop, c_eop, c_fd, c_uf;
  logic [2:0]  c_bc;
  logic [23:0] c_data;
  int          c_reads = 0;
  logic [23:0] c_bdat[$];
  logic [2:0]  c_bflag[$];

  fb_scanout #(.H_RES(16), .V_RES(1), .PIXEL_W(24), .ADDR_W(32), .BURST_LEN(4), .FIFO_DEPTH(8)) dut_c (
    .clk(clk), .reset(reset), .enable(c_en), .fb_base(32'h9000), .test_mode(1'b1),
    .avm_address(c_addr), .avm_read(c_read), .avm_burstcount(c_bc), .avm_waitrequest(1'b0),
    .avm_readdata(32'h0), .avm_readdatavalid(1'b0),
    .aso_data(c_data), .aso_valid(c_valid), .aso_ready(1'b1),
    .aso_startofpacket(c_sop), .aso_endofpacket(c_eop), .frame_done(c_fd), .underflow(c_uf));

  always @(negedge clk) begin
    if (c_read) c_reads++;
    if (c_valid) begin
      c_bdat.push_back(c_data);
      c_bflag.push_back({c_sop, c_eop, c_fd});
    end
  end
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int beats_of(input int which);
    if (which == 0) return a_bdat.size();
    if (which == 1) return b_bdat.size();
`ifdef FB_SCANOUT_TESTPAT_EN
    return c_bdat.size();
`else
    return 0;
`endif
  endfunction

  task automatic wait_beats(input int which, input int n, input int lim, input string tag);
    int t;
    t = 0;
    while (beats_of(which) < n && t < lim) begin
      step(1);
      t++;
    end
    chk(tag, 64'(beats_of(which) >= n), 64'(1));
  endtask

  task automatic check_frame(input int which, input logic [31:0] base, input int n, input string tag);
    logic [23:0] d;
    logic [2:0]  f;
    chk($sformatf("%s_count", tag), 64'(beats_of(which)), 64'(n));
    for (int i = 0; i < n; i++) begin
      d = 'x;
      f = 'x;
      if (i < beats_of(which)) begin
        d = (which == 0) ? a_bdat[i] : b_bdat[i];
        f = (which == 0) ? a_bflag[i] : b_bflag[i];
      end
      chk($sformatf("%s_data%0d", tag, i), 64'(d), 64'(px(base, i)));
      chk($sformatf("%s_flags%0d", tag, i), 64'(f), 64'({i == 0, i == n - 1, i == n - 1}));
    end
  endtask

  task automatic check_a_bursts(input logic [31:0] base, input string tag);
    chk($sformatf("%s_nbursts", tag), 64'(a_baddr.size()), 64'(4));
    for (int i = 0; i < 4 && i < a_baddr.size(); i++) begin
      chk($sformatf("%s_baddr%0d", tag, i), 64'(a_baddr[i]), 64'(base + 32'(16 * i)));
      chk($sformatf("%s_bcnt%0d", tag, i), 64'(a_bcnt[i]), 64'(4));
    end
  endtask

  task automatic clear_a;
    a_baddr.delete();
    a_bcnt.delete();
    a_bdat.delete();
    a_bflag.delete();
  endtask

  task automatic start_a(input logic [31:0] base);
    a_base = base;
    a_en   = 1'b1;
    step(1);
    a_en   = 1'b0;
  endtask

`ifdef FB_SCANOUT_TESTPAT_EN
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

  initial begin
    step(3);
    chk("rst_a_outs", {a_read, a_addr, a_bc, a_valid, a_sop, a_eop, a_fd, a_uf, a_data}, '0);
    chk("rst_b_outs", {b_read, b_addr, b_bc, b_valid, b_sop, b_eop, b_fd, b_uf, b_data}, '0);
    reset = 1'b0;
    step(2);

    // 1: basic frame, streaming sink
    a_ready = 1'b1;
    start_a(32'h1000);
    chk("t1_first_req", {a_read, a_addr, a_bc}, {1'b1, 32'h1000, 3'd4});
    wait_beats(0, 16, 300, "t1_wait");
    step(5);
    check_frame(0, 32'h1000, 16, "t1");
    check_a_bursts(32'h1000, "t1");
    chk("t1_idle", {a_read, a_valid}, 2'b00);
    clear_a();

    // 2: sink stalled, credit limits fetch to two bursts
    a_ready = 1'b0;
    start_a(32'h2000);
    step(40);
    chk("t2_nbursts_stalled", 64'(a_baddr.size()), 64'(2));
    chk("t2_read_low", 64'(a_read), 64'(0));
    chk("t2_head", {a_valid, a_sop, a_data}, {1'b1, 1'b1, 24'h5C2000});
    a_ready = 1'b1;
    wait_beats(0, 16, 300, "t2_wait");
    step(5);
    check_frame(0, 32'h2000, 16, "t2");
    check_a_bursts(32'h2000, "t2");
    clear_a();

    // 3: waitrequest holds the first request for 5 cycles
    a_wait = 1'b1;
    start_a(32'h3000);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_hold%0d", i), {a_read, a_addr, a_bc}, {1'b1, 32'h3000, 3'd4});
      step(1);
    end
    a_wait = 1'b0;
    chk("t3_hold5", {a_read, a_addr, a_bc}, {1'b1, 32'h3000, 3'd4});
    wait_beats(0, 16, 300, "t3_wait");
    step(5);
    check_frame(0, 32'h3000, 16, "t3");
    check_a_bursts(32'h3000, "t3");
    clear_a();

    // 3b: slow memory starves the stream mid-frame
    a_gap = 3;
    start_a(32'h4000);
    wait_beats(0, 16, 400, "t3b_wait");
    step(5);
    check_frame(0, 32'h4000, 16, "t3b");
    chk("t3b_underflow", 64'(a_uf), 64'(1));
    a_gap = 1;
    clear_a();

    // 4: 6x1 frame ends with a short burst
    b_base = 32'h8000;
    b_en   = 1'b1;
    step(1);
    b_en   = 1'b0;
    wait_beats(1, 6, 200, "t4_wait");
    step(5);
    check_frame(1, 32'h8000, 6, "t4");
    chk("t4_nbursts", 64'(b_baddr.size()), 64'(2));
    if (b_baddr.size() >= 2) begin
      chk("t4_b0", {b_baddr[0], 32'(b_bcnt[0])}, {32'h8000, 32'd4});
      chk("t4_b1", {b_baddr[1], 32'(b_bcnt[1])}, {32'h8010, 32'd2});
    end

    // 5a: enable dropped mid-frame, frame still completes then idles
    a_base = 32'h5000;
    a_en   = 1'b1;
    wait_beats(0, 3, 200, "t5_wait3");
    a_en   = 1'b0;
    wait_beats(0, 16, 300, "t5_wait");
    step(20);
    check_frame(0, 32'h5000, 16, "t5");
    check_a_bursts(32'h5000, "t5");
    chk("t5_idle", {a_read, a_valid}, 2'b00);
    clear_a();

    // 5b: reset mid-frame, late read data must be dropped
    start_a(32'h6000);
    wait_beats(0, 5, 200, "t5r_wait");
    reset = 1'b1;
    step(1);
    chk("t5r_outs", {a_read, a_addr, a_bc, a_valid, a_sop, a_eop, a_fd, a_uf, a_data}, '0);
    reset = 1'b0;
    step(20);
    chk("t5r_quiet", {a_read, a_valid}, 2'b00);
    clear_a();
    start_a(32'h7000);
    wait_beats(0, 16, 300, "t5r_wait2");
    step(5);
    check_frame(0, 32'h7000, 16, "t5r");
    check_a_bursts(32'h7000, "t5r");

`ifdef FB_SCANOUT_TESTPAT_EN
    // 6: colour bars, no memory traffic
    c_en = 1'b1;
    step(1);
    c_en = 1'b0;
    wait_beats(2, 16, 100, "t6_wait");
    step(3);
    chk("t6_count", 64'(c_bdat.size()), 64'(16));
    for (int i = 0; i < 16 && i < c_bdat.size(); i++) begin
      chk($sformatf("t6_data%0d", i), 64'(c_bdat[i]), 64'(bars[i / 2]));
      chk($sformatf("t6_flags%0d", i), 64'(c_bflag[i]), 64'({i == 0, i == 15, i == 15}));
    end
    chk("t6_no_reads", 64'(c_reads), 64'(0));
    chk("t6_underflow", 64'(c_uf), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
